// File: rtl/hw6_pkg.sv
// Shared definitions for the hw6 register-machine core: field widths, opcodes,
// decoded instruction layout and the fixed program ROM.
package hw6_pkg;

  localparam int DATA_W  = 8;
  localparam int PC_W    = 8;
  localparam int INS_W   = 16;
  localparam int RADDR_W = 4;
  localparam int NREGS   = 16;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDI = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;

  localparam logic [RADDR_W-1:0] REG_ZERO = 4'd0;
  localparam logic [RADDR_W-1:0] REG_PC   = 4'd15;

  typedef struct packed {
    logic [3:0]         op;
    logic [RADDR_W-1:0] rd;
    logic [RADDR_W-1:0] rs;
    logic [RADDR_W-1:0] rt;
  } ins_t;

  // Immediate of LDI occupies the rs/rt nibbles.
  function automatic logic [INS_W-1:0] rom_word(input logic [PC_W-1:0] addr);
    case (addr)
      8'd0:    rom_word = 16'h1105;
      8'd1:    rom_word = 16'h1203;
      8'd2:    rom_word = 16'h2312;
      8'd3:    rom_word = 16'h3412;
      8'd4:    rom_word = 16'h4512;
      8'd5:    rom_word = 16'h5612;
      8'd6:    rom_word = 16'h6712;
      8'd7:    rom_word = 16'h2112;
      default: rom_word = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/hw6_regfile.sv
// 16x8 register file: two combinational read ports, one synchronous write port.
// R0 always reads zero and ignores writes; synchronous active-low clear.
module hw6_regfile
  import hw6_pkg::*;
(
  input  logic               clock,
  input  logic               resetN,
  input  logic               wr_en,
  input  logic [RADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic [RADDR_W-1:0] a_addr,
  input  logic [RADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0]  a_data,
  output logic [DATA_W-1:0]  b_data
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clock) begin
    if (!resetN) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != REG_ZERO)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign a_data = (a_addr == REG_ZERO) ? '0 : regs[a_addr];
  assign b_data = (b_addr == REG_ZERO) ? '0 : regs[b_addr];

endmodule

// File: rtl/hw6_code.sv
// Single-cycle 8-bit register machine: executes ROM[R15] each edge, result to rd and out.
// R15 advances by one or loads jumpTo; no handshake, inputs sampled at the clock edge.
module hw6_code
  import hw6_pkg::*;
(
  input  logic              clock,
  input  logic              resetN,
  input  logic              selector,
  input  logic [PC_W-1:0]   jumpTo,
  output logic [PC_W-1:0]   R15output,
  output logic [DATA_W-1:0] out
);

  logic [PC_W-1:0]   pc;
  ins_t              ins;
  logic [DATA_W-1:0] a_raw, b_raw, a_op, b_op;
  logic [DATA_W-1:0] result;
  logic              exec_vld;
  logic              wr_en;

  assign ins = ins_t'(rom_word(pc));

  hw6_regfile u_regfile (
    .clock   (clock),
    .resetN  (resetN),
    .wr_en   (wr_en),
    .wr_addr (ins.rd),
    .wr_data (result),
    .a_addr  (ins.rs),
    .b_addr  (ins.rt),
    .a_data  (a_raw),
    .b_data  (b_raw)
  );

  // R15 lives here rather than in the file, so operand reads of R15 see the PC.
  assign a_op = (ins.rs == REG_PC) ? pc : a_raw;
  assign b_op = (ins.rt == REG_PC) ? pc : b_raw;

  always_comb begin
    result   = '0;
    exec_vld = 1'b1;
    case (ins.op)
      OP_LDI:  result = {ins.rs, ins.rt};
      OP_ADD:  result = a_op + b_op;
      OP_SUB:  result = a_op - b_op;
      OP_AND:  result = a_op & b_op;
      OP_OR:   result = a_op | b_op;
      OP_XOR:  result = a_op ^ b_op;
      default: exec_vld = 1'b0;
    endcase
  end

  assign wr_en = exec_vld && (ins.rd != REG_PC);

  always_ff @(posedge clock) begin
    if (!resetN) begin
      pc  <= '0;
      out <= '0;
    end else begin
      pc <= selector ? jumpTo : pc + 8'd1;
      if (exec_vld) out <= result;
    end
  end

  assign R15output = pc;

endmodule

// File: tb/tb_hw6_code.sv
// Scoreboard bench for hw6_code: stimulus pushes expected {R15output,out} per edge,
// a monitor pops and compares shortly after every rising edge.
module tb_hw6_code;

  logic       clock    = 1'b0;
  logic       resetN   = 1'b0;
  logic       selector = 1'b0;
  logic [7:0] jumpTo   = 8'd0;
  logic [7:0] R15output;
  logic [7:0] out;

  always #5 clock = ~clock;

  hw6_code dut (
    .clock     (clock),
    .resetN    (resetN),
    .selector  (selector),
    .jumpTo    (jumpTo),
    .R15output (R15output),
    .out       (out)
  );

  logic [15:0] exp_q [$];
  string       tag_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [15:0] mon_exp;
  string       mon_tag;

  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      n_checks++;
      if (R15output !== mon_exp[15:8]) begin
        n_fail++;
        $display("FAIL %s pc: got %0d expected %0d", mon_tag, R15output, mon_exp[15:8]);
      end
      n_checks++;
      if (out !== mon_exp[7:0]) begin
        n_fail++;
        $display("FAIL %s out: got %0d expected %0d", mon_tag, out, mon_exp[7:0]);
      end
    end
  end

  task automatic step(input logic rst, input logic sel, input logic [7:0] jt,
                      input logic [7:0] exp_pc, input logic [7:0] exp_out, input string tag);
    @(negedge clock);
    resetN   = rst;
    selector = sel;
    jumpTo   = jt;
    exp_q.push_back({exp_pc, exp_out});
    tag_q.push_back(tag);
    @(posedge clock);
  endtask

  logic [7:0] run_out [10] = '{8'd5, 8'd3, 8'd8, 8'd2, 8'd1, 8'd7, 8'd6, 8'd8, 8'd8, 8'd8};
  logic [7:0] r1;

  initial begin
    // Reset held for three edges.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, "reset");

    // Straight-line run from 0.
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b0, 8'd0, 8'(i + 1), run_out[i], $sformatf("run%0d", i));

    // Loop on SUB at address 3: first edge executes the NOP at 10.
    step(1'b1, 1'b1, 8'd3, 8'd3, 8'd8, "jmp3_first");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'd3, 8'd3, 8'd5, $sformatf("jmp3_%0d", i));

    // Loop on ADD R1 at address 7: R1 = 8 + 3k, wraps 254 -> 1.
    step(1'b1, 1'b1, 8'd7, 8'd7, 8'd5, "jmp7_first");
    r1 = 8'd8;
    for (int k = 1; k <= 83; k++) begin
      r1 = r1 + 8'd3;
      step(1'b1, 1'b1, 8'd7, 8'd7, r1, $sformatf("acc%0d", k));
    end

    // Jump to 255, then PC wraps to 0 across a NOP; out holds.
    r1 = r1 + 8'd3;
    step(1'b1, 1'b1, 8'd255, 8'd255, r1, "jmp255");
    step(1'b1, 1'b0, 8'd0, 8'd0, r1, "wrap_nop");
    step(1'b1, 1'b0, 8'd0, 8'd1, 8'd5, "wrap_ldi1");
    step(1'b1, 1'b0, 8'd0, 8'd2, 8'd3, "wrap_ldi2");
    step(1'b1, 1'b0, 8'd0, 8'd3, 8'd8, "wrap_add");

    // Mid-run reset overrides a pending jump.
    step(1'b0, 1'b1, 8'd200, 8'd0, 8'd0, "mid_reset");
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 8'd0, 8'(i + 1), run_out[i], $sformatf("rerun%0d", i));

    @(negedge clock);
    @(negedge clock);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
